alu_share_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 8-bit ALU of the nRISC core. Each requester presents an ALU operation (control code, operands, shift amount) on a valid/ready channel. The block grants one request at a time and drives the ALU from registered operand lines. It captures the combinational result and flag, then returns them on a single response channel tagged with the requester id. It sits between the ALU and its two clients: the main datapath (requester 0) and the address/branch unit (requester 1).

---
 rtl/alu_share_arbiter.sv | 95 +++++++++
 tb/tb_alu_share_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two-requester round-robin sequencer for the shared ALU (optional ALU_DIVZERO_TRAP_EN)
module alu_share_arbiter #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [2:0]         req0_op,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [2:0]         req1_op,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic [2:0]         alu_ctrl,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_zero,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state;
  logic   prio;
  logic   win;
  logic   take;
  logic   trap;
`ifdef ALU_DIVZERO_TRAP_EN
  assign trap = (alu_ctrl == 3'b011) && (alu_b == '0);
`else
  assign trap = 1'b0;
`endif
  // grant: the lone valid requester wins, prio breaks a tie; only offered in IDLE
  always_comb begin
    win        = req1_valid && (!req0_valid || prio);
    req0_ready = (state == IDLE) && req0_valid && !win;
    req1_ready = (state == IDLE) && win;
    take       = req0_ready || req1_ready;
  end
  // sequencer: accept, drive ALU for one cycle, capture, hold response until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      alu_ctrl  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_shamt <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          alu_ctrl  <= win ? req1_op : req0_op;
          alu_a     <= win ? req1_a : req0_a;
          alu_b     <= win ? req1_b : req0_b;
          alu_shamt <= win ? req1_shamt : req0_shamt;
          rsp_id    <= win;
          prio      <= !win;
          busy      <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          rsp_data  <= trap ? '1 : alu_out;
          rsp_zero  <= alu_zero;
          rsp_err   <= trap;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed checks of grant, latency, backpressure, reset abort and divide trap
module tb_alu_share_arbiter;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DIV = 3'b011;
  localparam logic [2:0] AND = 3'b100, SLT = 3'b101, SLL = 3'b110, SRL = 3'b111;
  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op, alu_ctrl;
  logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
  logic [2:0] req0_shamt, req1_shamt, alu_shamt;
  logic rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, alu_zero, busy;
  int total = 0, passed = 0, fails = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_out(alu_out), .alu_zero(alu_zero), .busy(busy)
  );

  // reference ALU; divide by zero returns a marker value
  always_comb begin
    case (alu_ctrl)
      ADD:     alu_out = alu_a + alu_b;
      SUB:     alu_out = alu_a - alu_b;
      MUL:     alu_out = 8'(alu_a * alu_b);
      DIV:     alu_out = (alu_b == 8'h00) ? 8'h5A : alu_a / alu_b;
      AND:     alu_out = alu_a & alu_b;
      SLT:     alu_out = {7'b0, alu_a < alu_b};
      SLL:     alu_out = alu_a << alu_shamt;
      default: alu_out = alu_a >> alu_shamt;
    endcase
    alu_zero = alu_a == alu_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sh);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh;
  endtask

  task automatic set1(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sh);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rsp_valid), 1);
  endtask

  initial begin
    logic [7:0] held;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set0(0, ADD, 0, 0, 0);
    set1(0, ADD, 0, 0, 0);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 0);
    chk("rst_req0_ready", 32'(req0_ready), 0);
    set1(1, ADD, 0, 0, 0);
    #1 chk("rst_req1_ready_grant", 32'(req1_ready), 1);
    set1(0, ADD, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    set0(1, ADD, 8'h05, 8'h03, 0);
    #1 chk("add_req0_ready", 32'(req0_ready), 1);
    chk("add_req1_ready", 32'(req1_ready), 0);
    @(negedge clk);
    chk("issue_busy", 32'(busy), 1);
    chk("issue_rsp_valid", 32'(rsp_valid), 0);
    chk("issue_req0_ready", 32'(req0_ready), 0);
    chk("issue_alu_a", 32'(alu_a), 'h05);
    chk("issue_alu_b", 32'(alu_b), 'h03);
    chk("issue_alu_ctrl", 32'(alu_ctrl), 0);
    set0(0, ADD, 8'h05, 8'h03, 0);
    @(negedge clk);
    chk("add_rsp_valid", 32'(rsp_valid), 1);
    chk("add_rsp_id", 32'(rsp_id), 0);
    chk("add_rsp_data", 32'(rsp_data), 'h08);
    chk("add_rsp_zero", 32'(rsp_zero), 0);
    chk("add_rsp_err", 32'(rsp_err), 0);
    @(negedge clk);
    chk("add_done_valid", 32'(rsp_valid), 0);
    chk("add_done_busy", 32'(busy), 0);

    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    set0(1, SUB, 8'h09, 8'h09, 0);
    set1(1, SLL, 8'h01, 8'h00, 3'd3);
    #1 chk("tie_req0_ready", 32'(req0_ready), 1);
    chk("tie_req1_ready", 32'(req1_ready), 0);
    for (int k = 0; k < 4; k++) begin
      wait_rsp("rr_rsp_timeout");
      chk("rr_id", 32'(rsp_id), 32'(k % 2));
      chk("rr_data", 32'(rsp_data), (k % 2) ? 'h08 : 'h00);
      chk("rr_zero", 32'(rsp_zero), (k % 2) ? 0 : 1);
      @(negedge clk);
      if (k == 0) begin
        chk("rr_req1_turn", 32'(req1_ready), 1);
        chk("rr_req0_wait", 32'(req0_ready), 0);
      end
    end

    set0(0, SUB, 8'h09, 8'h09, 0);
    set1(1, DIV, 8'h10, 8'h00, 0);
    rsp_ready = 1'b0;
    wait_rsp("div_rsp_timeout");
    chk("div_id", 32'(rsp_id), 1);
    chk("div_zero", 32'(rsp_zero), 0);
`ifdef ALU_DIVZERO_TRAP_EN
    chk("div_data", 32'(rsp_data), 'hFF);
    chk("div_err", 32'(rsp_err), 1);
`else
    chk("div_data", 32'(rsp_data), 'h5A);
    chk("div_err", 32'(rsp_err), 0);
`endif
    held = rsp_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data_stable", 32'(rsp_data), 32'(held));
      chk("bp_req1_ready", 32'(req1_ready), 0);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_req1_ready", 32'(req1_ready), 0);
    @(negedge clk);
    chk("bp_after_valid", 32'(rsp_valid), 0);
    chk("bp_after_req1_ready", 32'(req1_ready), 1);
    @(posedge clk) #1 set1(0, DIV, 8'h10, 8'h00, 0);
    wait_rsp("div2_rsp_timeout");
    chk("div2_id", 32'(rsp_id), 1);
    @(negedge clk);

    set0(1, ADD, 8'h01, 8'h01, 0);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 1);
    set0(0, ADD, 8'h01, 8'h01, 0);
    rst_n = 1'b0;
    #1 chk("abort_busy", 32'(busy), 0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_alu_a", 32'(alu_a), 0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 0);
    end
    set0(1, MUL, 8'h20, 8'h10, 0);
    set1(1, SLT, 8'h02, 8'h07, 0);
    #1 chk("abort_tie_req0", 32'(req0_ready), 1);
    chk("abort_tie_req1", 32'(req1_ready), 0);
    wait_rsp("mul_rsp_timeout");
    chk("mul_id", 32'(rsp_id), 0);
    chk("mul_data", 32'(rsp_data), 'h00);
    chk("mul_zero", 32'(rsp_zero), 0);
    @(negedge clk);
    set0(0, MUL, 8'h20, 8'h10, 0);
    wait_rsp("slt_rsp_timeout");
    set1(0, SLT, 8'h02, 8'h07, 0);
    chk("slt_id", 32'(rsp_id), 1);
    chk("slt_data", 32'(rsp_data), 'h01);
    @(negedge clk);
    chk("hold_busy", 32'(busy), 0);
    chk("hold_alu_a", 32'(alu_a), 'h02);
    chk("hold_alu_b", 32'(alu_b), 'h07);
    chk("hold_alu_ctrl", 32'(alu_ctrl), 32'(SLT));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
